tl_acquire_responder: RTL

TL_ACQUIRE_RESPONDER -- requirements
Module: tl_acquire_responder

---
 rtl/tl_acquire_responder_if.sv | 53 +++++
 rtl/tl_acquire_responder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/tl_acquire_responder_if.sv
// TileLink A/D/E channel bundle plus the backing-memory read port.
// The responder is the slave; the requesting agent and the memory are the master side.
interface tl_acquire_responder_if;
  logic         a_valid;
  logic         a_ready;
  logic [2:0]   a_opcode;
  logic [2:0]   a_param;
  logic [3:0]   a_size;
  logic [2:0]   a_source;
  logic [31:0]  a_address;

  logic         d_valid;
  logic         d_ready;
  logic [2:0]   d_opcode;
  logic [1:0]   d_param;
  logic [3:0]   d_size;
  logic [2:0]   d_source;
  logic [3:0]   d_sink;
  logic         d_denied;
  logic [127:0] d_data;

  logic         e_valid;
  logic         e_ready;
  logic [3:0]   e_sink;

  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data,
    input  d_ready,
    input  e_valid, e_sink,
    output e_ready,
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data,
    output d_ready,
    output e_valid, e_sink,
    input  e_ready,
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/tl_acquire_responder.sv
// Single-outstanding TileLink Acquire responder: fetches a block beat by beat from
// memory, returns Grant/GrantData/AccessAck on D and waits for GrantAck on E.
module tl_acquire_responder #(
  parameter int          BEATS   = 4,
  parameter logic [3:0]  SINK_ID = 4'h0
) (
  input  logic                    clock,
  input  logic                    reset,
  tl_acquire_responder_if.slave   tl,
  output logic                    busy,
  output logic                    sink_err
);

  localparam int                OFFSET_BITS = $clog2(BEATS * 16);
  localparam int                BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BEATS - 1);
  localparam logic [31:0]       BASE_MASK   = ~(32'((1 << OFFSET_BITS) - 1));

  localparam logic [2:0] OP_ACQUIRE_BLOCK = 3'd6;
  localparam logic [2:0] OP_ACQUIRE_PERM  = 3'd7;
  localparam logic [2:0] OP_ACCESS_ACK    = 3'd0;
  localparam logic [2:0] OP_GRANT         = 3'd4;
  localparam logic [2:0] OP_GRANT_DATA    = 3'd5;

  typedef enum logic [2:0] {IDLE, MEMREQ, MEMWAIT, SEND, WAITACK} state_t;

  state_t              state, state_nxt;
  logic [2:0]          opcode_q;
  logic [2:0]          param_q;
  logic [3:0]          size_q;
  logic [2:0]          source_q;
  logic [31:0]         base_q;
  logic [BEAT_W-1:0]   beat;
  logic [127:0]        beat_buf;

  logic                a_ready_int;
  logic                d_valid_int;
  logic                e_ready_int;
  logic                mem_req_valid_int;
  logic                accept;
  logic                is_block;
  logic                is_perm;
  logic [2:0]          d_opcode_int;
  logic [1:0]          d_param_int;
  logic                d_denied_int;
  logic [127:0]        d_data_int;

  assign accept   = a_ready_int & tl.a_valid;
  assign is_block = (opcode_q == OP_ACQUIRE_BLOCK);
  assign is_perm  = (opcode_q == OP_ACQUIRE_PERM);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // a_ready is gated by reset so it stays low for the whole reset window.
  always_comb begin
    state_nxt         = state;
    a_ready_int       = 1'b0;
    d_valid_int       = 1'b0;
    e_ready_int       = 1'b0;
    mem_req_valid_int = 1'b0;
    case (state)
      IDLE: begin
        a_ready_int = ~reset;
        if (tl.a_valid && !reset) begin
          if (tl.a_opcode == OP_ACQUIRE_BLOCK) state_nxt = MEMREQ;
          else                                 state_nxt = SEND;
        end
      end
      MEMREQ: begin
        mem_req_valid_int = 1'b1;
        if (tl.mem_req_ready) state_nxt = MEMWAIT;
      end
      MEMWAIT: begin
        if (tl.mem_resp_valid) state_nxt = SEND;
      end
      SEND: begin
        d_valid_int = 1'b1;
        if (tl.d_ready) begin
          if (is_block)     state_nxt = (beat == LAST_BEAT) ? WAITACK : MEMREQ;
          else if (is_perm) state_nxt = WAITACK;
          else              state_nxt = IDLE;
        end
      end
      WAITACK: begin
        e_ready_int = 1'b1;
        if (tl.e_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      opcode_q <= '0;
      param_q  <= '0;
      size_q   <= '0;
      source_q <= '0;
      base_q   <= '0;
      beat     <= '0;
      beat_buf <= '0;
      sink_err <= 1'b0;
    end else begin
      if (accept) begin
        opcode_q <= tl.a_opcode;
        param_q  <= tl.a_param;
        size_q   <= tl.a_size;
        source_q <= tl.a_source;
        base_q   <= tl.a_address & BASE_MASK;
        beat     <= '0;
      end
      if (state == MEMWAIT && tl.mem_resp_valid) beat_buf <= tl.mem_resp_data;
      if (state == SEND && tl.d_ready && is_block && beat != LAST_BEAT) beat <= beat + 1'b1;
      if (state == WAITACK && tl.e_valid && tl.e_sink != SINK_ID) sink_err <= 1'b1;
    end
  end

  // D fields come only from latched request state, so they hold while d_ready is low.
  always_comb begin
    d_opcode_int = OP_ACCESS_ACK;
    d_param_int  = 2'd0;
    d_denied_int = 1'b1;
    d_data_int   = '0;
    if (is_block || is_perm) begin
      d_opcode_int = is_block ? OP_GRANT_DATA : OP_GRANT;
      d_data_int   = is_block ? beat_buf : '0;
      d_denied_int = 1'b0;
      case (param_q)
        3'd0:    d_param_int = 2'd1;
        3'd1,
        3'd2:    d_param_int = 2'd0;
        default: begin
          d_param_int  = 2'd2;
          d_denied_int = 1'b1;
        end
      endcase
    end
  end

  assign tl.a_ready       = a_ready_int;
  assign tl.d_valid       = d_valid_int;
  assign tl.d_opcode      = d_opcode_int;
  assign tl.d_param       = d_param_int;
  assign tl.d_size        = size_q;
  assign tl.d_source      = source_q;
  assign tl.d_sink        = SINK_ID;
  assign tl.d_denied      = d_denied_int;
  assign tl.d_data        = d_data_int;
  assign tl.e_ready       = e_ready_int;
  assign tl.mem_req_valid = mem_req_valid_int;
  assign tl.mem_req_addr  = base_q + {{(28 - BEAT_W){1'b0}}, beat, 4'b0000};
  assign busy             = (state != IDLE);

endmodule
